// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V program loader: state encoding and frame constants.
package riscv_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned LEN_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Assembles little-endian bytes into instruction words and flags the byte that completes a word.
module loader_word_asm #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            shift,
  input  logic [7:0]      data,
  output logic            word_done_c,
  output logic [XLEN-1:0] word_c
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned IW    = $clog2(BYTES);

  logic [IW-1:0]     idx;
  logic [XLEN-9:0]   sr;

  // Newest byte lands on top, so after the last byte the oldest sits in bits [7:0].
  assign word_c      = {data, sr};
  assign word_done_c = shift && (idx == IW'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (shift) begin
      idx <= idx + IW'(1);
      sr  <= word_c[XLEN-1:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for IMEM; holds the core in reset until a frame passes its checksum.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_DEPTH = 128,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  output logic                         imem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] imem_addr,
  output logic [XLEN-1:0]              imem_wdata,
  output logic                         core_rst,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  loader_state_e    state;
  logic [7:0]       len_lo;
  logic [7:0]       csum;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len_in;
  logic             accept;
  logic             word_done_c;
  logic [XLEN-1:0]  word_c;

  // No backpressure: ready whenever not in reset.
  assign rx_ready = !rst;
  assign accept   = rx_valid && rx_ready;
  assign len_in   = {rx_data, len_lo};

  loader_word_asm #(.XLEN(XLEN)) u_word_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept && (state == ST_LEN_HI)),
    .shift       (accept && (state == ST_DATA)),
    .data        (rx_data),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            // Sync restarts a frame from any resting state.
            if (rx_data == SYNC_BYTE) begin
              state    <= ST_LEN_LO;
              csum     <= '0;
              core_rst <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
            end
          end
          ST_LEN_LO: begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len      <= len_in;
            word_cnt <= '0;
            if (len_in > LEN_W'(MEM_DEPTH)) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else if (len_in == '0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum <= csum ^ rx_data;
            if (word_done_c) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[AW-1:0];
              imem_wdata <= word_c;
              word_cnt   <= word_cnt + LEN_W'(1);
              if (word_cnt == len - LEN_W'(1)) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes and status come from a frame-level model.
module tb_imem_loader;
  import riscv_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_DEPTH = 128;
  localparam int unsigned AW        = $clog2(MEM_DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;
  logic            core_rst;
  logic            busy;
  logic            done;
  logic            err;

  int checks   = 0;
  int failures = 0;
  bit gaps     = 1'b0;

  logic [XLEN-1:0]    dut_mem [MEM_DEPTH];
  logic [XLEN-1:0]    exp_mem [MEM_DEPTH];
  logic [AW+XLEN-1:0] wq [$];
  logic [XLEN-1:0]    frame_words [$];

  always #5 clk = ~clk;

  imem_loader #(
    .XLEN      (XLEN),
    .MEM_DEPTH (MEM_DEPTH),
    .SYNC_BYTE (SYNC_BYTE_DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Write monitor: one sample per write-strobe cycle, mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq.push_back({imem_addr, imem_wdata});
      dut_mem[imem_addr] = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] non_sync();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == SYNC_BYTE_DEF) b = 8'($urandom);
    return b;
  endfunction

  task automatic fill_words(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back(XLEN'($urandom));
  endtask

  // Sends one frame built from frame_words and checks the outcome the frame rules predict.
  task automatic run_frame(input string tag, input int n, input bit ok);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] len;
    cs  = 8'h00;
    len = 16'(n);
    wq.delete();
    send_byte(SYNC_BYTE_DEF);
    check({tag, "/sync_busy"}, busy, 1);
    check({tag, "/sync_core_rst"}, core_rst, 1);
    check({tag, "/sync_done"}, done, 0);
    check({tag, "/sync_err"}, err, 0);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    if (n > int'(MEM_DEPTH)) begin
      check({tag, "/over_err"}, err, 1);
      check({tag, "/over_busy"}, busy, 0);
      repeat (4) send_byte(non_sync());
      repeat (2) @(negedge clk);
      check({tag, "/over_err_hold"}, err, 1);
      check({tag, "/over_core_rst"}, core_rst, 1);
      check({tag, "/over_writes"}, wq.size(), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = frame_words[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
      end
    end
    check({tag, "/pre_cs_core_rst"}, core_rst, 1);
    send_byte(ok ? cs : (cs ^ 8'h5A));
    check({tag, "/done"}, done, ok);
    check({tag, "/err"}, err, !ok);
    check({tag, "/core_rst"}, core_rst, !ok);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/nwrites"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check({tag, "/write"}, wq[i], {AW'(i), frame_words[i]});
    end
    for (int i = 0; i < n; i++) exp_mem[i] = frame_words[i];
  endtask

  initial begin
    int hi;
    int n;
    bit ok;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      dut_mem[i] = '0;
      exp_mem[i] = '0;
    end
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/rx_ready", rx_ready, 0);
    check("rst/imem_we", imem_we, 0);
    check("rst/imem_addr", imem_addr, 0);
    check("rst/imem_wdata", imem_wdata, 0);
    check("rst/core_rst", core_rst, 1);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst/rx_ready_rel", rx_ready, 1);

    // Garbage in IDLE is discarded
    gaps = 1'b1;
    repeat (4) send_byte(non_sync());
    check("idle/busy", busy, 0);
    check("idle/core_rst", core_rst, 1);
    check("idle/done", done, 0);

    // Nominal load
    gaps = 1'b0;
    frame_words.delete();
    frame_words.push_back(32'h00A00093);
    frame_words.push_back(32'h01400113);
    run_frame("nominal", 2, 1'b1);

    // Bad checksum: writes land, core stays in reset
    run_frame("badcs", 2, 1'b0);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (core_rst) hi++;
    end
    check("badcs/hold50", hi, 50);

    // Oversize count
    frame_words.delete();
    run_frame("oversize", int'(MEM_DEPTH) + 1, 1'b1);

    // Zero length with random valid gaps
    gaps = 1'b1;
    run_frame("zero", 0, 1'b1);

    // Reload after DONE
    fill_words(1);
    run_frame("reload", 1, 1'b1);

    // Mid-frame reset after byte 2 of word 0
    wq.delete();
    gaps = 1'b0;
    send_byte(SYNC_BYTE_DEF);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst/busy", busy, 0);
    check("midrst/core_rst", core_rst, 1);
    check("midrst/imem_we", imem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst/nwrites", wq.size(), 0);
    check("midrst/done", done, 0);
    fill_words(3);
    run_frame("after_midrst", 3, 1'b1);

    // Randomized frames, including the full-depth boundary
    for (int f = 0; f < 12; f++) begin
      gaps = 1'($urandom_range(0, 1));
      ok   = ($urandom_range(0, 3) != 0);
      n    = (f == 5) ? int'(MEM_DEPTH) + 1 :
             (f == 8) ? int'(MEM_DEPTH) : int'($urandom_range(0, 6));
      fill_words((n > int'(MEM_DEPTH)) ? 0 : n);
      run_frame("rand", n, ok);
    end

    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      check("mem_image", dut_mem[i], exp_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
